// File: rtl/aes_spi_ctrl.sv
// Frame controller between the SPI slave and a shared AES core.
// Validates requests, sequences one or two core passes, builds responses.
module aes_spi_ctrl #(
  parameter int BLOCK_W     = 128,
  parameter int KEY_W_MAX   = 256,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16,
  parameter int FRAME_W     = BLOCK_W + 16 + KEY_W_MAX,
  parameter int RESP_W      = 2 * BLOCK_W + 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_valid,
  input  logic [FRAME_W-1:0]   frame_data,
  output logic                 resp_valid,
  output logic [RESP_W-1:0]    resp_data,
  output logic                 core_start,
  output logic                 core_mode,
  output logic [1:0]           core_key_len,
  output logic [BLOCK_W-1:0]   core_data,
  output logic [KEY_W_MAX-1:0] core_key,
  input  logic                 core_done,
  input  logic [BLOCK_W-1:0]   core_result,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, RUN1, RUN2, RESP
  } state_t;

  state_t state, state_n;

  logic [FRAME_W-1:0]   req;
  logic [BLOCK_W-1:0]   req_blk;
  logic [7:0]           req_kl;
  logic [7:0]           req_mode;
  logic [KEY_W_MAX-1:0] req_key;

  logic [BLOCK_W-1:0] res0, res1, res0_n, res1_n;
  logic [6:0]         code, code_n, chk_code;
  logic               overrun, ovr_n;
  logic [TW-1:0]      wait_cnt;
  logic               kl_ok, mode_ok, rt;
  logic [1:0]         kl_code;
  logic               run, expire, tmo;

  assign req_blk  = req[FRAME_W-1 -: BLOCK_W];
  assign req_kl   = req[KEY_W_MAX+15 -: 8];
  assign req_mode = req[KEY_W_MAX+7 -: 8];
  assign req_key  = req[KEY_W_MAX-1:0];
  assign rt       = (req_mode == 8'd2);

  assign run    = (state == RUN1) || (state == RUN2);
  assign expire = run && (wait_cnt == TMAX);
  assign tmo    = expire && !core_done;

  always_comb begin
    kl_ok   = 1'b1;
    kl_code = 2'd0;
    unique case (1'b1)
      (req_kl == 8'd16): kl_code = 2'd0;
      (req_kl == 8'd24): kl_code = 2'd1;
      (req_kl == 8'd32): kl_code = 2'd2;
      default:           kl_ok   = 1'b0;
    endcase
    mode_ok  = (req_mode <= 8'd2);
    chk_code = !kl_ok   ? 7'd1 :
               !mode_ok ? 7'd2 : 7'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (frame_valid) state_n = CHECK;
      CHECK: state_n = (kl_ok && mode_ok) ? RUN1 : RESP;
      RUN1: begin
        if (core_done)   state_n = rt ? RUN2 : RESP;
        else if (expire) state_n = RESP;
      end
      RUN2:  if (core_done || expire) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = (state == RESP);
    core_start = run && (wait_cnt == '0);
    busy       = (state != IDLE);
  end

  // Next-cycle result view, so the response can be built on entry to RESP.
  always_comb begin
    res0_n = res0;
    res1_n = res1;
    code_n = code;
    if (state == CHECK) code_n = chk_code;
    if (state == RUN1 && core_done) res0_n = core_result;
    if (state == RUN2 && core_done) res1_n = core_result;
    if (tmo) code_n = 7'd3;
    ovr_n = overrun | frame_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req          <= '0;
      res0         <= '0;
      res1         <= '0;
      code         <= '0;
      overrun      <= 1'b0;
      wait_cnt     <= '0;
      resp_data    <= '0;
      core_mode    <= 1'b0;
      core_key_len <= 2'd0;
      core_data    <= '0;
      core_key     <= '0;
      frame_cnt    <= '0;
    end else begin
      if (state == IDLE && frame_valid) begin
        req  <= frame_data;
        res0 <= '0;
        res1 <= '0;
        code <= '0;
      end else begin
        res0 <= res0_n;
        res1 <= res1_n;
        code <= code_n;
      end

      if (state == RESP)                     overrun <= frame_valid;
      else if (state != IDLE && frame_valid) overrun <= 1'b1;

      wait_cnt <= (run && state_n == state) ? wait_cnt + TW'(1) : '0;

      if (state == CHECK && state_n == RUN1) begin
        core_data    <= req_blk;
        core_key     <= req_key;
        core_mode    <= (req_mode == 8'd1);
        core_key_len <= kl_code;
      end

      if (state == RUN1 && core_done && rt) begin
        core_data <= core_result;
        core_mode <= 1'b1;
      end

      if (state_n == RESP)
        resp_data <= {res0_n, res1_n, ovr_n, code_n};

      if (state == RESP) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// Directed bench for aes_spi_ctrl with a lookup-table AES core model.
// Table vectors plus overrun, reset-abort and counter-wrap sequences.
module tb_aes_spi_ctrl;

  localparam int BW = 128;
  localparam int KW = 256;
  localparam int FW = BW + 16 + KW;
  localparam int RW = 2 * BW + 8;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] XB   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] MC   = {16{8'ha5}};
  localparam logic [127:0] MI   = {16{8'h3c}};
  localparam logic [255:0] K128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 =
    {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KJNK =
    {128'h000102030405060708090a0b0c0d0e0f,
     128'hdeadbeefdeadbeefdeadbeefdeadbeef};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_valid = 1'b0;
  logic [FW-1:0] frame_data = '0;
  logic          resp_valid;
  logic [RW-1:0] resp_data;
  logic          core_start;
  logic          core_mode;
  logic [1:0]    core_key_len;
  logic [BW-1:0] core_data;
  logic [KW-1:0] core_key;
  logic          core_done = 1'b0;
  logic [BW-1:0] core_result = '0;
  logic          busy;
  logic [3:0]    frame_cnt;

  aes_spi_ctrl #(
    .BLOCK_W(BW), .KEY_W_MAX(KW), .TIMEOUT_CYC(8), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .frame_valid(frame_valid), .frame_data(frame_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .core_start(core_start), .core_mode(core_mode),
    .core_key_len(core_key_len), .core_data(core_data),
    .core_key(core_key), .core_done(core_done),
    .core_result(core_result), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Core model: known FIPS-197 vectors, otherwise a mode-dependent mask.
  function automatic logic [127:0] ref_core(
    input logic m, input logic [1:0] kl,
    input logic [255:0] k, input logic [127:0] d);
    if (!m && kl == 2'd0 && k == K128 && d == PT) return C128;
    if (!m && kl == 2'd2 && k == K256 && d == PT) return C256;
    if (m && kl == 2'd2 && k == K256 && d == C256) return PT;
    if (m && kl == 2'd1 && k == K192 && d == C192) return PT;
    return d ^ (m ? MI : MC);
  endfunction

  int           n_starts = 0;
  int           core_lat = 2;
  bit           core_en = 1'b1;
  bit           pend = 1'b0;
  int           pend_cnt = 0;
  logic [127:0] pend_res = '0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        core_done   = 1'b1;
        core_result = pend_res;
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (core_start) begin
      n_starts++;
      if (core_en) begin
        pend     = 1'b1;
        pend_cnt = core_lat;
        pend_res = ref_core(core_mode, core_key_len, core_key, core_data);
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;

  task automatic chk(input string nm, input logic [263:0] act,
                     input logic [263:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic do_frame(
    input  logic [7:0]   kl, input logic [7:0] md,
    input  logic [255:0] key, input logic [127:0] blk,
    input  int           pulse_at,
    output int           lat, output logic [RW-1:0] rd,
    output logic         b1, output int starts);
    int s0;
    s0  = n_starts;
    lat = -1;
    rd  = '0;
    b1  = 1'b0;
    @(negedge clk);
    frame_data  = {blk, kl, md, key};
    frame_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      frame_valid = (k == pulse_at);
      if (k == 1) b1 = busy;
      if (resp_valid) begin
        lat = k;
        rd  = resp_data;
        break;
      end
    end
    if (frame_valid) begin
      @(negedge clk);
      frame_valid = 1'b0;
    end
    @(negedge clk);
    starts = n_starts - s0;
  endtask

  typedef struct {
    logic [7:0]   kl;
    logic [7:0]   md;
    logic [255:0] key;
    logic [127:0] blk;
    int           clat;
    logic [127:0] r0;
    logic [127:0] r1;
    logic [7:0]   st;
    int           starts;
    int           rlat;
  } vec_t;

  vec_t vt[12];

  task automatic run_chk(input string nm, input logic [7:0] kl,
    input logic [7:0] md, input logic [255:0] key,
    input logic [127:0] blk, input int pulse_at,
    input logic [127:0] r0, input logic [127:0] r1,
    input logic [7:0] st, input int starts, input int rlat);
    int lat, ns;
    logic [RW-1:0] rd;
    logic b1;
    do_frame(kl, md, key, blk, pulse_at, lat, rd, b1, ns);
    exp_cnt = (exp_cnt + 1) % 16;
    chk({nm, " latency"}, 264'(lat), 264'(rlat));
    chk({nm, " res0"}, 264'(rd[263:136]), 264'(r0));
    chk({nm, " res1"}, 264'(rd[135:8]), 264'(r1));
    chk({nm, " status"}, 264'(rd[7:0]), 264'(st));
    chk({nm, " starts"}, 264'(ns), 264'(starts));
    chk({nm, " busy"}, 264'(b1), 264'(1));
    chk({nm, " frame_cnt"}, 264'(frame_cnt), 264'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nresp;
    vt[0]  = '{8'd16, 8'd0, K128, PT,   2, C128,    128'h0, 8'h00, 1, 5};
    vt[1]  = '{8'd32, 8'd2, K256, PT,   2, C256,    PT,     8'h00, 2, 8};
    vt[2]  = '{8'd24, 8'd1, K192, C192, 2, PT,      128'h0, 8'h00, 1, 5};
    vt[3]  = '{8'h14, 8'd0, K128, PT,   2, 128'h0,  128'h0, 8'h01, 0, 2};
    vt[4]  = '{8'd16, 8'd7, K128, PT,   2, 128'h0,  128'h0, 8'h02, 0, 2};
    vt[5]  = '{8'h14, 8'd7, K128, PT,   2, 128'h0,  128'h0, 8'h01, 0, 2};
    vt[6]  = '{8'd32, 8'd3, K256, PT,   2, 128'h0,  128'h0, 8'h02, 0, 2};
    vt[7]  = '{8'd16, 8'd0, K128, XB,   7, XB ^ MC, 128'h0, 8'h00, 1, 10};
    vt[8]  = '{8'd16, 8'd0, K128, XB,   8, 128'h0,  128'h0, 8'h03, 1, 10};
    vt[9]  = '{8'd24, 8'd2, K192, PT,   1, PT ^ MC, PT ^ MC ^ MI,
               8'h00, 2, 6};
    vt[10] = '{8'd16, 8'd1, KJNK, XB,   2, XB ^ MI, 128'h0, 8'h00, 1, 5};
    vt[11] = '{8'd33, 8'd0, K256, PT,   2, 128'h0,  128'h0, 8'h01, 0, 2};

    repeat (3) @(negedge clk);
    chk("rst resp_valid", 264'(resp_valid), 264'(0));
    chk("rst resp_data", 264'(resp_data), 264'(0));
    chk("rst core_start", 264'(core_start), 264'(0));
    chk("rst busy", 264'(busy), 264'(0));
    chk("rst frame_cnt", 264'(frame_cnt), 264'(0));
    chk("rst core_key", 264'(core_key), 264'(0));
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      core_lat = vt[i].clat;
      run_chk($sformatf("v%0d", i), vt[i].kl, vt[i].md, vt[i].key,
              vt[i].blk, 0, vt[i].r0, vt[i].r1, vt[i].st,
              vt[i].starts, vt[i].rlat);
    end

    // Core never answers; a frame arriving mid-RUN1 is flagged.
    core_en = 1'b0;
    run_chk("ovr_run1", 8'd16, 8'd0, K128, PT, 3,
            128'h0, 128'h0, 8'h83, 1, 10);
    core_en  = 1'b1;
    core_lat = 2;
    run_chk("ovr_clear", 8'd16, 8'd0, K128, PT, 0,
            C128, 128'h0, 8'h00, 1, 5);
    run_chk("ovr_in_resp", 8'h14, 8'd0, K128, PT, 2,
            128'h0, 128'h0, 8'h01, 0, 2);
    run_chk("ovr_report", 8'h14, 8'd0, K128, PT, 0,
            128'h0, 128'h0, 8'h81, 0, 2);
    run_chk("ovr_after", 8'h14, 8'd0, K128, PT, 0,
            128'h0, 128'h0, 8'h01, 0, 2);

    // Reset while the second core pass is outstanding.
    nresp = 0;
    @(negedge clk);
    frame_data  = {PT, 8'd32, 8'd2, K256};
    frame_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      frame_valid = 1'b0;
      if (resp_valid) nresp++;
      if (k == 5) chk("abort run2 start", 264'(core_start), 264'(1));
      if (k == 6) reset = 1'b1;
      if (k == 7) begin
        chk("abort resp_valid", 264'(resp_valid), 264'(0));
        chk("abort resp_data", 264'(resp_data), 264'(0));
        chk("abort core_start", 264'(core_start), 264'(0));
        chk("abort core_mode", 264'(core_mode), 264'(0));
        chk("abort core_key_len", 264'(core_key_len), 264'(0));
        chk("abort core_data", 264'(core_data), 264'(0));
        chk("abort core_key", 264'(core_key), 264'(0));
        chk("abort busy", 264'(busy), 264'(0));
        chk("abort frame_cnt", 264'(frame_cnt), 264'(0));
        reset = 1'b0;
      end
    end
    chk("abort no resp", 264'(nresp), 264'(0));
    exp_cnt = 0;

    for (int i = 0; i < 17; i++)
      run_chk($sformatf("wrap%0d", i), 8'h14, 8'd0, K128, PT, 0,
              128'h0, 128'h0, 8'h01, 0, 2);
    chk("wrap final", 264'(frame_cnt), 264'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
